// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline definitions for the hazard controller.
//   Opcode constants, forward-select encoding, controller state enum and
//   small decode helpers for instruction source usage and register matching.
package cpu_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    function automatic logic uses_rs(input logic [5:0] op);
        return !(op == OP_J || op == OP_JAL);
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
    endfunction

    // Register 0 is hard-wired, so a producer targeting it never matches.
    function automatic logic reg_hit(input logic rw, input logic [4:0] rd, input logic [4:0] r);
        return rw && rd != 5'd0 && rd == r;
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
//   IR_ID                      instruction in IDSeg
//   ex_rw/ex_mr/ex_rd          EX-stage producer (write, load, dest)
//   mem_rw/mem_mr/mem_rd       MEM-stage producer (write, load, dest)
//   ex_br_taken                branch in EX resolved taken
//   pc_we/ifid_we              PC and IF/ID write enables (0 = hold)
//   ifid_flush/idex_bubble     flush IF/ID, insert NOP into ID/EX
//   fwd_a/fwd_b                registered forward selects for EX
//   stall_cycles               saturating stall-cycle counter
//   master = pipeline side, slave = controller side.
interface hazard_ctrl_if;
    import cpu_pkg::*;
    logic [31:0] IR_ID;
    logic        ex_rw, ex_mr;
    logic [4:0]  ex_rd;
    logic        mem_rw, mem_mr;
    logic [4:0]  mem_rd;
    logic        ex_br_taken;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble;
    fwd_sel_t    fwd_a, fwd_b;
    logic [15:0] stall_cycles;

    modport master (
        output IR_ID, ex_rw, ex_mr, ex_rd, mem_rw, mem_mr, mem_rd, ex_br_taken,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cycles
    );
    modport slave (
        input  IR_ID, ex_rw, ex_mr, ex_rd, mem_rw, mem_mr, mem_rd, ex_br_taken,
        output pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cycles
    );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: combinational RAW hazard detection for the IDSeg instruction.
//   IR_ID, ex_rw/ex_mr/ex_rd, mem_rw/mem_rd in; hazard flag and stall length n out.
//   HAZARD_FWD_EN defined: only load-use on the EX producer stalls, n=1.
//   HAZARD_FWD_EN undefined: EX match stalls 2 cycles, MEM match 1 cycle.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [31:0] IR_ID,
    input  logic        ex_rw,
    input  logic        ex_mr,
    input  logic [4:0]  ex_rd,
    input  logic        mem_rw,
    input  logic [4:0]  mem_rd,
    output logic        hazard,
    output logic [1:0]  n
);
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       ex_hit, mem_hit, unused_ir;

    assign op = IR_ID[31:26];
    assign rs = IR_ID[25:21];
    assign rt = IR_ID[20:16];
    assign unused_ir = ^IR_ID[15:0];

    assign ex_hit  = (uses_rs(op) && reg_hit(ex_rw, ex_rd, rs)) || (uses_rt(op) && reg_hit(ex_rw, ex_rd, rt));
    assign mem_hit = (uses_rs(op) && reg_hit(mem_rw, mem_rd, rs)) || (uses_rt(op) && reg_hit(mem_rw, mem_rd, rt));

`ifdef HAZARD_FWD_EN
    logic unused_mem;
    assign unused_mem = mem_hit;
    assign hazard = ex_hit && ex_mr;
    assign n = 2'd1;
`else
    logic unused_mr;
    assign unused_mr = ex_mr;
    assign hazard = ex_hit || mem_hit;
    assign n = ex_hit ? 2'd2 : 2'd1;
`endif
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller with optional forwarding.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   bus          hazard_ctrl_if.slave (instruction, producers, branch in;
//                enables, flush/bubble, forward selects, stall counter out)
//   HAZARD_FWD_EN: enables registered forward selects and load-use-only stalls.
module hazard_ctrl
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    state_t     state, state_n;
    logic [1:0] cnt, cnt_n, n;
    logic       hazard, hold, is_jump, unused_mem_mr;

    assign unused_mem_mr = bus.mem_mr;
    assign is_jump = !uses_rs(bus.IR_ID[31:26]);

    hazard_detect u_detect (
        .IR_ID  (bus.IR_ID),
        .ex_rw  (bus.ex_rw),
        .ex_mr  (bus.ex_mr),
        .ex_rd  (bus.ex_rd),
        .mem_rw (bus.mem_rw),
        .mem_rd (bus.mem_rd),
        .hazard (hazard),
        .n      (n)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // A taken branch wins; STALL ignores new hazards and counts down.
    always_comb begin
        state_n = bus.ex_br_taken ? RUN : (state == STALL) ? (cnt == 2'd1 ? RUN : STALL) : (hazard && n > 2'd1 ? STALL : RUN);
        cnt_n   = bus.ex_br_taken ? 2'd0 : (state == STALL) ? cnt - 2'd1 : (hazard && n > 2'd1 ? n - 2'd1 : cnt);
    end

    always_comb begin
        hold            = state == STALL || hazard;
        bus.pc_we       = bus.ex_br_taken || !hold;
        bus.ifid_we     = bus.ex_br_taken || !hold;
        bus.idex_bubble = bus.ex_br_taken || hold;
        bus.ifid_flush  = bus.ex_br_taken || (!hold && is_jump);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bus.stall_cycles <= 16'd0;
        else if (!bus.pc_we && bus.stall_cycles != 16'hFFFF)
            bus.stall_cycles <= bus.stall_cycles + 16'd1;
    end

`ifdef HAZARD_FWD_EN
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       ex_fw;
    fwd_sel_t   fa_n, fb_n;

    assign op    = bus.IR_ID[31:26];
    assign rs    = bus.IR_ID[25:21];
    assign rt    = bus.IR_ID[20:16];
    assign ex_fw = bus.ex_rw && !bus.ex_mr;

    // A bubble or flush sends a NOP down, which needs no forwarding.
    always_comb begin
        fa_n = bus.idex_bubble || bus.ifid_flush ? FWD_RF :
               uses_rs(op) && reg_hit(ex_fw, bus.ex_rd, rs) ? FWD_EXMEM :
               uses_rs(op) && reg_hit(bus.mem_rw, bus.mem_rd, rs) ? FWD_MEMWB : FWD_RF;
        fb_n = bus.idex_bubble || bus.ifid_flush ? FWD_RF :
               uses_rt(op) && reg_hit(ex_fw, bus.ex_rd, rt) ? FWD_EXMEM :
               uses_rt(op) && reg_hit(bus.mem_rw, bus.mem_rd, rt) ? FWD_MEMWB : FWD_RF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.fwd_a <= FWD_RF;
            bus.fwd_b <= FWD_RF;
        end else begin
            bus.fwd_a <= fa_n;
            bus.fwd_b <= fb_n;
        end
    end
`else
    assign bus.fwd_a = FWD_RF;
    assign bus.fwd_b = FWD_RF;
`endif
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on the rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 IR_ID  in  32  instruction currently in the IDSeg stage (opcode [31:26], rs [25:21], rt [20:16]).
REQ-004 ex_rw / ex_mr / ex_rd  in  1/1/5  EX-stage producer: register write, load, destination register.
REQ-005 mem_rw / mem_mr / mem_rd  in  1/1/5  MEM-stage producer: register write, load, destination register.
REQ-006 ex_br_taken  in  1  branch in EX resolved as taken this cycle.
REQ-007 pc_we / ifid_we  out  1/1  PC write enable and IF/ID write enable (0 = hold).
REQ-008 ifid_flush / idex_bubble  out  1/1  flush IF/ID to NOP; load NOP into ID/EX.
REQ-009 fwd_a / fwd_b  out  2/2  registered forward selects for the instruction now in EX: 00 regfile, 01 EX/MEM, 10 MEM/WB.
REQ-010 stall_cycles  out  16  saturating count of stall cycles since reset.

Function
REQ-011 Source use: uses_rs for every opcode except 000010/000011; uses_rt for opcodes 000000, 000100, 000101 and 101011.
REQ-012 Register 0 never creates a hazard or a forward.
REQ-013 IDSeg register file is write-through, so a WB-stage producer needs no stall and no forward.
REQ-014 FSM states: RUN and STALL; 2-bit down-counter cnt.
REQ-015 RUN, hazard needing N stall cycles: pc_we=0, ifid_we=0, idex_bubble=1 this cycle.
- N>1: enter STALL with cnt=N-1.
- N=1: remain in RUN.
REQ-016 STALL: same three outputs asserted; hazard inputs ignored; cnt decrements each cycle; return to RUN on the edge where cnt==1.
REQ-017 ex_br_taken=1 overrides everything in the same cycle:
- ifid_flush=1, idex_bubble=1, pc_we=1, ifid_we=1.
- state goes to RUN; cnt clears to 0.
REQ-018 Jump opcode (000010/000011) in IR_ID with no stall active: ifid_flush=1 for one cycle.
REQ-019 No hazard and no flush: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
REQ-020 fwd_a/fwd_b update only on edges where ID/EX advances; bubble or flush loads 00.
- EX producer (non-load) matching the source register loads 01.
- Otherwise a MEM producer matching loads 10.
- EX match takes priority over MEM match.
REQ-021 stall_cycles increments on each cycle with pc_we=0 and saturates at 0xFFFF.

Reset
REQ-022 rst=0 forces immediately: state RUN, cnt=0, fwd_a=fwd_b=00, stall_cycles=0.
REQ-023 Combinational outputs follow the RUN rules while in reset.
REQ-024 Reset asserted mid-STALL abandons the stall with no residual bubble after release.

Configuration
REQ-025 Macro HAZARD_FWD_EN defined (forwarding on):
- only load-use stalls (ex_mr=1 and ex_rd matches) with N=1.
- forwarding per REQ-020.
REQ-026 Macro HAZARD_FWD_EN undefined (forwarding off):
- fwd_a/fwd_b tied to 00.
- any RAW match with an EX producer gives N=2; with a MEM producer gives N=1.
- EX match takes priority over MEM match.

Structure
REQ-027 Shared package cpu_pkg holds:
- opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_J, OP_JAL).
- fwd_sel_t encoding 00/01/10.
- state enum {RUN, STALL}.
REQ-028 One sub-module, hazard_detect: purely combinational, produces the hazard flag and N from IR_ID and the producer inputs; the FSM and counters stay in hazard_ctrl.

Verification
REQ-029 HAZARD_FWD_EN, IR_ID=0x00221820 (add $3,$1,$2), ex_rw=1, ex_mr=1, ex_rd=1 -> exactly 1 cycle with pc_we=0 and idex_bubble=1; stall_cycles=1.
REQ-030 HAZARD_FWD_EN, same IR_ID, ex_rw=1, ex_mr=0, ex_rd=2 -> no stall; fwd_b=01 and fwd_a=00 after the edge.
REQ-031 No forwarding, same IR_ID, ex_rw=1, ex_rd=1 -> pc_we=0 for exactly 2 consecutive cycles, then 1.
REQ-032 ex_br_taken=1 during STALL (cnt=1) -> ifid_flush=1, idex_bubble=1, pc_we=1 that cycle; RUN next cycle.
REQ-033 rst=0 pulse mid-STALL -> state RUN, stall_cycles=0, fwd selects 00 without waiting for a clock edge.
REQ-034 Hold a permanent stall for 65540 cycles -> stall_cycles=0xFFFF and holds there.
